// File: rtl/voice_alloc_if.sv
// Event, free and issue signals between the MIDI decoder/sample engine and the voice allocator.
// master drives events and frees; slave is the allocator.
interface voice_alloc_if #(
   parameter int unsigned VOICE_BITS = 7
);
   logic                  ev_valid;
   logic                  ev_ready;
   logic                  ev_on;
   logic [6:0]            ev_note;
   logic [3:0]            ev_channel;
   logic [6:0]            ev_velocity;
   logic                  free_valid;
   logic [VOICE_BITS-1:0] free_voice;
   logic                  out_pressed;
   logic                  out_released;
   logic [7:0]            out_addr;
   logic [6:0]            out_note;
   logic [3:0]            out_channel;
   logic [6:0]            out_velocity;
   logic                  stolen;
   logic [VOICE_BITS:0]   active_count;

   modport master (
      output ev_valid, ev_on, ev_note, ev_channel, ev_velocity, free_valid, free_voice,
      input  ev_ready, out_pressed, out_released, out_addr, out_note, out_channel,
             out_velocity, stolen, active_count
   );

   modport slave (
      input  ev_valid, ev_on, ev_note, ev_channel, ev_velocity, free_valid, free_voice,
      output ev_ready, out_pressed, out_released, out_addr, out_note, out_channel,
             out_velocity, stolen, active_count
   );
endinterface

// File: rtl/voice_alloc.sv
// Polyphonic voice allocator: maps note-on/off events to synth voice slots with retrigger,
// free-slot reuse and oldest-voice stealing, via a sequential scan of the slot table.
module voice_alloc #(
   parameter int unsigned VOICE_BITS = 7
) (
   input logic            i_clk96,
   input logic            i_rst,
   voice_alloc_if.slave   io_bus
);
   localparam int unsigned NumVoices = 2 ** VOICE_BITS;
   localparam logic [VOICE_BITS:0] MaxCount = (VOICE_BITS + 1)'(NumVoices);
   localparam logic [VOICE_BITS:0] OneCount = (VOICE_BITS + 1)'(1);

   typedef enum logic [1:0] {StIdle, StScan, StIssue} state_e;
   typedef logic [VOICE_BITS-1:0] slot_t;

   state_e              r_state;
   logic                r_ready;
   logic [VOICE_BITS:0] r_idx;
   logic [NumVoices-1:0] r_busy;
   logic [NumVoices-1:0] r_held;
   logic [15:0]         r_stamp_ctr;
   logic [VOICE_BITS:0] r_active;

   logic                r_ev_on;
   logic [6:0]          r_ev_note;
   logic [3:0]          r_ev_ch;
   logic [6:0]          r_ev_vel;

   // Slot table payload: 1-cycle read RAM, no reset.
   logic [6:0]          r_note_mem  [NumVoices];
   logic [3:0]          r_chan_mem  [NumVoices];
   logic [15:0]         r_stamp_mem [NumVoices];

   logic                r_rd_vld;
   slot_t               r_rd_slot;
   logic                r_rd_busy;
   logic                r_rd_held;
   logic [6:0]          r_rd_note;
   logic [3:0]          r_rd_chan;
   logic [15:0]         r_rd_stamp;

   logic                r_match_vld, r_free_vld, r_rel_vld, r_old_vld;
   slot_t               r_match_idx, r_free_idx, r_rel_idx, r_old_idx;
   logic [15:0]         r_rel_age, r_old_age;

   slot_t               r_sel;
   logic                r_wr_on;
   logic                r_wr_off;

   logic                r_pressed;
   logic                r_released;
   logic                r_stolen;
   logic [7:0]          r_out_addr;
   logic [6:0]          r_out_note;
   logic [3:0]          r_out_ch;
   logic [6:0]          r_out_vel;

   logic                w_match_vld, w_free_vld, w_rel_vld, w_old_vld;
   slot_t               w_match_idx, w_free_idx, w_rel_idx, w_old_idx;
   logic [15:0]         w_rel_age, w_old_age;
   logic [15:0]         w_age;
   slot_t               w_on_sel;
   logic                w_steal;
   logic                w_issue_on;
   logic                w_inc;
   logic                w_dec;

   always_comb begin
      w_age       = r_stamp_ctr - r_rd_stamp;
      w_match_vld = r_match_vld;
      w_match_idx = r_match_idx;
      w_free_vld  = r_free_vld;
      w_free_idx  = r_free_idx;
      w_rel_vld   = r_rel_vld;
      w_rel_idx   = r_rel_idx;
      w_rel_age   = r_rel_age;
      w_old_vld   = r_old_vld;
      w_old_idx   = r_old_idx;
      w_old_age   = r_old_age;
      if (r_rd_vld) begin
         if (!r_match_vld && r_rd_busy && r_rd_held && (r_rd_note == r_ev_note) &&
             (r_rd_chan == r_ev_ch)) begin
            w_match_vld = 1'b1;
            w_match_idx = r_rd_slot;
         end
         if (!r_free_vld && !r_rd_busy) begin
            w_free_vld = 1'b1;
            w_free_idx = r_rd_slot;
         end
         // Strict compare keeps the lowest index on equal age.
         if (r_rd_busy && !r_rd_held && (!r_rel_vld || (w_age > r_rel_age))) begin
            w_rel_vld = 1'b1;
            w_rel_idx = r_rd_slot;
            w_rel_age = w_age;
         end
         if (r_rd_busy && (!r_old_vld || (w_age > r_old_age))) begin
            w_old_vld = 1'b1;
            w_old_idx = r_rd_slot;
            w_old_age = w_age;
         end
      end
      w_on_sel = w_old_idx;
      if (w_rel_vld) w_on_sel = w_rel_idx;
      if (w_free_vld) w_on_sel = w_free_idx;
      if (w_match_vld) w_on_sel = w_match_idx;
      w_steal = !w_match_vld && !w_free_vld;
   end

   always_comb begin
      w_issue_on = (r_state == StIssue) && r_wr_on;
      w_inc      = w_issue_on && !r_busy[r_sel];
      w_dec      = io_bus.free_valid && r_busy[io_bus.free_voice] &&
                   !(w_issue_on && (io_bus.free_voice == r_sel));
   end

   always_ff @(posedge i_clk96) begin
      if (w_issue_on) begin
         r_note_mem[r_sel]  <= r_ev_note;
         r_chan_mem[r_sel]  <= r_ev_ch;
         r_stamp_mem[r_sel] <= r_stamp_ctr;
      end
      if ((r_state == StScan) && !r_idx[VOICE_BITS]) begin
         r_rd_note  <= r_note_mem[r_idx[VOICE_BITS-1:0]];
         r_rd_chan  <= r_chan_mem[r_idx[VOICE_BITS-1:0]];
         r_rd_stamp <= r_stamp_mem[r_idx[VOICE_BITS-1:0]];
      end
   end

   always_ff @(posedge i_clk96) begin
      if (i_rst) begin
         r_state     <= StIdle;
         r_ready     <= 1'b0;
         r_idx       <= '0;
         r_busy      <= '0;
         r_held      <= '0;
         r_stamp_ctr <= '0;
         r_active    <= '0;
         r_ev_on     <= 1'b0;
         r_ev_note   <= '0;
         r_ev_ch     <= '0;
         r_ev_vel    <= '0;
         r_rd_vld    <= 1'b0;
         r_rd_slot   <= '0;
         r_rd_busy   <= 1'b0;
         r_rd_held   <= 1'b0;
         r_match_vld <= 1'b0;
         r_free_vld  <= 1'b0;
         r_rel_vld   <= 1'b0;
         r_old_vld   <= 1'b0;
         r_match_idx <= '0;
         r_free_idx  <= '0;
         r_rel_idx   <= '0;
         r_old_idx   <= '0;
         r_rel_age   <= '0;
         r_old_age   <= '0;
         r_sel       <= '0;
         r_wr_on     <= 1'b0;
         r_wr_off    <= 1'b0;
         r_pressed   <= 1'b0;
         r_released  <= 1'b0;
         r_stolen    <= 1'b0;
         r_out_addr  <= '0;
         r_out_note  <= '0;
         r_out_ch    <= '0;
         r_out_vel   <= '0;
      end else begin
         r_pressed  <= 1'b0;
         r_released <= 1'b0;
         r_stolen   <= 1'b0;

         // Later issue writes below override this clear on the same slot.
         if (io_bus.free_valid) begin
            r_busy[io_bus.free_voice] <= 1'b0;
            r_held[io_bus.free_voice] <= 1'b0;
         end
         if (w_inc && !w_dec && (r_active != MaxCount)) begin
            r_active <= r_active + OneCount;
         end else if (w_dec && !w_inc && (r_active != '0)) begin
            r_active <= r_active - OneCount;
         end

         unique case (r_state)
            StIdle: begin
               if (r_ready && io_bus.ev_valid) begin
                  r_ev_on     <= io_bus.ev_on;
                  r_ev_note   <= io_bus.ev_note;
                  r_ev_ch     <= io_bus.ev_channel;
                  r_ev_vel    <= io_bus.ev_velocity;
                  r_idx       <= '0;
                  r_rd_vld    <= 1'b0;
                  r_match_vld <= 1'b0;
                  r_free_vld  <= 1'b0;
                  r_rel_vld   <= 1'b0;
                  r_old_vld   <= 1'b0;
                  r_ready     <= 1'b0;
                  r_state     <= StScan;
               end else begin
                  r_ready <= 1'b1;
               end
            end
            StScan: begin
               r_rd_vld    <= !r_idx[VOICE_BITS];
               r_rd_slot   <= r_idx[VOICE_BITS-1:0];
               r_rd_busy   <= r_busy[r_idx[VOICE_BITS-1:0]];
               r_rd_held   <= r_held[r_idx[VOICE_BITS-1:0]];
               r_idx       <= r_idx + OneCount;
               r_match_vld <= w_match_vld;
               r_match_idx <= w_match_idx;
               r_free_vld  <= w_free_vld;
               r_free_idx  <= w_free_idx;
               r_rel_vld   <= w_rel_vld;
               r_rel_idx   <= w_rel_idx;
               r_rel_age   <= w_rel_age;
               r_old_vld   <= w_old_vld;
               r_old_idx   <= w_old_idx;
               r_old_age   <= w_old_age;
               if (r_idx[VOICE_BITS]) begin
                  r_state  <= StIssue;
                  r_wr_on  <= r_ev_on;
                  r_wr_off <= !r_ev_on && w_match_vld;
                  r_sel    <= r_ev_on ? w_on_sel : w_match_idx;
                  if (r_ev_on || w_match_vld) begin
                     r_pressed  <= r_ev_on;
                     r_released <= !r_ev_on;
                     r_stolen   <= r_ev_on && w_steal;
                     r_out_addr <= 8'(r_ev_on ? w_on_sel : w_match_idx);
                     r_out_note <= r_ev_note;
                     r_out_ch   <= r_ev_ch;
                     r_out_vel  <= r_ev_vel;
                  end
               end
            end
            StIssue: begin
               if (r_wr_on) begin
                  r_busy[r_sel] <= 1'b1;
                  r_held[r_sel] <= 1'b1;
                  r_stamp_ctr   <= r_stamp_ctr + 16'd1;
               end
               if (r_wr_off) begin
                  r_held[r_sel] <= 1'b0;
               end
               r_wr_on  <= 1'b0;
               r_wr_off <= 1'b0;
               r_ready  <= 1'b1;
               r_state  <= StIdle;
            end
            default: begin
               r_state <= StIdle;
            end
         endcase
      end
   end

   assign io_bus.ev_ready     = r_ready;
   assign io_bus.out_pressed  = r_pressed;
   assign io_bus.out_released = r_released;
   assign io_bus.out_addr     = r_out_addr;
   assign io_bus.out_note     = r_out_note;
   assign io_bus.out_channel  = r_out_ch;
   assign io_bus.out_velocity = r_out_vel;
   assign io_bus.stolen       = r_stolen;
   assign io_bus.active_count = r_active;
endmodule

// File: tb/tb_voice_alloc.sv
// Directed bench for voice_alloc: each event pushes its expected outcome to a scoreboard,
// which is popped and checked once the allocator's N+3 cycle window has elapsed.
module tb_voice_alloc;
   localparam int VB = 7;
   localparam int N  = 1 << VB;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   voice_alloc_if #(.VOICE_BITS(VB)) bus ();
   voice_alloc #(.VOICE_BITS(VB)) dut (.i_clk96(clk), .i_rst(rst), .io_bus(bus));

   typedef struct {
      int kind;  // 0 none, 1 pressed, 2 released
      int addr;
      int stl;
      int note;
      int ch;
      int vel;
      int act;
   } exp_t;

   exp_t sb[$];
   int n_chk  = 0;
   int n_pass = 0;
   int ev_id  = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         $error("FAIL %s (event %0d): observed %0d required %0d", tag, ev_id, obs, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      bus.ev_valid = 1'b0;
      bus.free_valid = 1'b0;
      @(negedge clk);
      chk("rst_ready", 32'(bus.ev_ready), 0);
      chk("rst_pressed", 32'(bus.out_pressed), 0);
      chk("rst_released", 32'(bus.out_released), 0);
      chk("rst_addr", 32'(bus.out_addr), 0);
      chk("rst_note", 32'(bus.out_note), 0);
      chk("rst_active", 32'(bus.active_count), 0);
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_ready", 32'(bus.ev_ready), 1);
   endtask

   task automatic run_event(input int on, input int note, input int ch, input int vel,
                            input int kind, input int addr, input int stl, input int act,
                            input int free_at_issue);
      exp_t e;
      exp_t o;
      int   got = 0;
      int   n_strobes = 0;
      int   strobe_k = -1;
      int   ready_k = -1;
      ev_id++;
      e.kind = kind; e.addr = addr; e.stl = stl; e.note = note; e.ch = ch; e.vel = vel;
      e.act = act;
      sb.push_back(e);
      o = e;
      @(negedge clk);
      bus.ev_valid    = 1'b1;
      bus.ev_on       = 1'(on);
      bus.ev_note     = 7'(note);
      bus.ev_channel  = 4'(ch);
      bus.ev_velocity = 7'(vel);
      for (int w = 0; w < 20 && got == 0; w++) begin
         if (bus.ev_ready === 1'b1) got = 1;
         else @(negedge clk);
      end
      chk("accept", 32'(got), 1);
      if (got == 0) begin
         bus.ev_valid = 1'b0;
         void'(sb.pop_front());
         return;
      end
      for (int k = 1; k <= N + 3; k++) begin
         @(negedge clk);
         if (k == 1) bus.ev_valid = 1'b0;
         if (bus.out_pressed === 1'b1 || bus.out_released === 1'b1) begin
            n_strobes++;
            if (strobe_k < 0) begin
               strobe_k = k;
               o.kind = (bus.out_pressed ? 1 : 0) + (bus.out_released ? 2 : 0);
               o.addr = int'(bus.out_addr);
               o.stl  = int'(bus.stolen);
               o.note = int'(bus.out_note);
               o.ch   = int'(bus.out_channel);
               o.vel  = int'(bus.out_velocity);
            end
         end
         if (ready_k < 0 && bus.ev_ready === 1'b1) ready_k = k;
         if (k == N + 2 && free_at_issue >= 0) begin
            bus.free_valid = 1'b1;
            bus.free_voice = VB'(free_at_issue);
         end
         if (k == N + 3) bus.free_valid = 1'b0;
      end
      e = sb.pop_front();
      chk("strobe_count", 32'(n_strobes), (e.kind != 0) ? 1 : 0);
      if (e.kind != 0) begin
         chk("strobe_cycle", 32'(strobe_k), 32'(N + 2));
         chk("strobe_kind", 32'(o.kind), 32'(e.kind));
         chk("out_addr", 32'(o.addr), 32'(e.addr));
         chk("out_note", 32'(o.note), 32'(e.note));
         chk("out_channel", 32'(o.ch), 32'(e.ch));
         chk("out_velocity", 32'(o.vel), 32'(e.vel));
         if (e.kind == 1) chk("stolen", 32'(o.stl), 32'(e.stl));
      end
      chk("ready_return", 32'(ready_k), 32'(N + 3));
      chk("active_count", 32'(bus.active_count), 32'(e.act));
   endtask

   task automatic free_pulse(input int voice, input int act);
      @(negedge clk);
      bus.free_valid = 1'b1;
      bus.free_voice = VB'(voice);
      @(negedge clk);
      bus.free_valid = 1'b0;
      chk("free_active", 32'(bus.active_count), 32'(act));
   endtask

   initial begin
      int n_str;
      bus.ev_valid = 1'b0; bus.ev_on = 1'b0; bus.ev_note = '0; bus.ev_channel = '0;
      bus.ev_velocity = '0; bus.free_valid = 1'b0; bus.free_voice = '0;

      do_reset();
      run_event(1, 60, 0, 100, 1, 0, 0, 1, -1);
      run_event(1, 62, 0, 90, 1, 1, 0, 2, -1);
      run_event(0, 62, 0, 33, 2, 1, 0, 2, -1);
      free_pulse(1, 1);

      do_reset();
      run_event(1, 60, 0, 100, 1, 0, 0, 1, -1);
      run_event(1, 60, 0, 101, 1, 0, 0, 1, -1);
      run_event(1, 60, 1, 80, 1, 1, 0, 2, -1);

      // Fill every slot, release the third-issued note, then steal twice.
      do_reset();
      for (int i = 0; i < N; i++) run_event(1, i, 0, 64, 1, i, 0, i + 1, -1);
      run_event(0, 2, 0, 10, 2, 2, 0, N, -1);
      run_event(1, 5, 3, 70, 1, 2, 1, N, -1);
      run_event(1, 6, 3, 71, 1, 0, 1, N, -1);

      // Free colliding with an issue write to the same slot.
      do_reset();
      for (int i = 0; i < 5; i++) run_event(1, 10 + i, 0, 50, 1, i, 0, i + 1, -1);
      run_event(1, 20, 0, 90, 1, 5, 0, 6, 5);
      run_event(1, 20, 0, 91, 1, 5, 0, 6, 5);
      run_event(1, 20, 0, 92, 1, 5, 0, 6, -1);
      run_event(0, 100, 9, 5, 0, 0, 0, 6, -1);

      // Reset in the middle of a scan aborts the event.
      ev_id++;
      @(negedge clk);
      bus.ev_valid = 1'b1; bus.ev_on = 1'b1; bus.ev_note = 7'd50; bus.ev_channel = 4'd2;
      bus.ev_velocity = 7'd40;
      chk("midscan_ready", 32'(bus.ev_ready), 1);
      @(negedge clk);
      bus.ev_valid = 1'b0;
      repeat (40) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_str = 0;
      for (int k = 0; k < N + 5; k++) begin
         @(negedge clk);
         if (bus.out_pressed === 1'b1 || bus.out_released === 1'b1) n_str++;
      end
      chk("midscan_strobes", 32'(n_str), 0);
      chk("midscan_active", 32'(bus.active_count), 0);
      chk("midscan_ready_after", 32'(bus.ev_ready), 1);
      run_event(1, 70, 0, 20, 1, 0, 0, 1, -1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/voice_alloc.md
# voice_alloc

Polyphonic voice allocator between the MIDI decoder and `synth2`. Each note-on/note-off event is mapped to a voice slot address in the synth voice RAM and re-issued as a single-cycle `note_pressed`/`note_released` strobe with that `addr`. It tracks which slots are sounding, retriggers repeated notes on the same slot and steals the oldest voice when all slots are busy. Slots are returned to the free pool by a free strobe from the sample engine when a release envelope reaches silence.

## Interface
Parameters:
- `VOICE_BITS`, default 7: slot index width; `N = 2^VOICE_BITS` voices (128 default, matching the synth voice RAM).

Ports:
- `clk96`, in, 1: system clock, 96 MHz.
- `rst`, in, 1: reset. One clock; reset is synchronous and active-high.
- `ev_valid`, in, 1: event request from the MIDI decoder.
- `ev_ready`, out, 1: the allocator is idle and accepts an event.
- `ev_on`, in, 1: 1 = note-on, 0 = note-off.
- `ev_note`, in, 7: MIDI note number.
- `ev_channel`, in, 4: MIDI channel.
- `ev_velocity`, in, 7: MIDI velocity.
- `free_valid`, in, 1: pulse; slot `free_voice` has gone silent.
- `free_voice`, in, VOICE_BITS: index of the slot being freed.
- `out_pressed`, out, 1: one-cycle strobe; drives synth `note_pressed`.
- `out_released`, out, 1: one-cycle strobe; drives synth `note_released`.
- `out_addr`, out, 8: slot index, zero-extended.
- `out_note`, out, 7: note of the issued event.
- `out_channel`, out, 4: channel of the issued event.
- `out_velocity`, out, 7: velocity of the issued event.
- `stolen`, out, 1: pulses with `out_pressed` when the chosen slot was already busy with a different note.
- `active_count`, out, VOICE_BITS+1: number of busy slots.

## Operation
- Per-slot state:
  - `busy` and `held` flags in flops; cleared by reset.
  - `note` (7 bits), `channel` (4 bits) and a 16-bit `stamp` in a RAM with 1-cycle read; contents undefined after reset and never used while `busy`=0.
- Global 16-bit `stamp_ctr`:
  - reset value 0;
  - +1 on every note-on ISSUE, wrapping;
  - slot age = `stamp_ctr - stamp`, mod 2^16.
- FSM states: IDLE → SCAN → ISSUE → IDLE.
  - IDLE: `ev_ready`=1. When `ev_valid`=1, latch the event fields and go to SCAN.
  - SCAN: read slots 0..N-1 one per cycle, tracking these candidates:
    - lowest busy&held slot whose note and channel match the event;
    - lowest non-busy slot;
    - oldest busy slot with `held`=0;
    - oldest busy slot overall.
    - Age ties resolve to the lowest index.
  - ISSUE, note-on: choose the first existing candidate in this order: match (retrigger), free, oldest released, oldest overall.
    - Write `busy`=1, `held`=1, note, channel and `stamp`=`stamp_ctr` to the chosen slot.
    - Pulse `out_pressed`.
    - Pulse `stolen` if the slot was busy and was not the match.
  - ISSUE, note-off with a match: clear `held` on the matched slot and pulse `out_released`.
  - ISSUE, note-off without a match: no strobe, no table change.
- `out_note`, `out_channel`, `out_velocity` and `out_addr` update in the ISSUE cycle and hold until the next ISSUE.
- `free_valid` is honoured in any state and clears `busy` and `held` of `free_voice`.
  - If it targets the slot being written in the same ISSUE cycle, the ISSUE write wins.
  - A free arriving during SCAN does not change the decision already being formed.
- `active_count`:
  - +1 on note-on ISSUE to a non-busy slot;
  - −1 on `free_valid` of a busy slot that is not being written in the same cycle;
  - both events in one cycle net to no change;
  - saturates at N and at 0.
- Aftertouch (keypress) and pitch-wheel events are not routed through this block.

## Timing
- Acceptance at edge T (`ev_valid`&`ev_ready`).
  - `ev_ready` goes low at T+1.
  - SCAN occupies N+1 cycles (N reads plus the final compare).
  - The strobe is high for exactly one cycle, at T+N+2.
  - `ev_ready` returns high at T+N+3.
- Fixed latency independent of outcome; a missing note-off match still takes N+3 cycles.
- `ev_valid` while `ev_ready`=0 is ignored. The decoder holds the event until accepted.
- Reset values:
  - `ev_ready`=0 during `rst`, 1 from the first cycle after;
  - all strobes 0, all `out_*` 0;
  - `active_count`=0, `stamp_ctr`=0, FSM in IDLE.
- Reset mid-SCAN aborts the event with no strobe.
- Worst case is ~1.3 µs per event at N=128, far below MIDI byte spacing.

## Test plan
- After reset, note-on (60, ch0, vel 100): `out_pressed` at T+130, `out_addr`=0, `stolen`=0, `active_count`=1.
- Note-on 60 then 62, then note-off 62 on ch0: `out_pressed` addr 0, then addr 1; `out_released` addr 1; `active_count` stays 2 until `free_valid` for voice 1, then 1.
- Note-on 60 on ch0 twice: both strobes use addr 0 (retrigger), `stolen`=0, `active_count`=1. Note-on 60 on ch1: addr 1.
- Fill all 128 slots, note-off the slot holding the third-issued note, then a new note-on: the allocator steals that released slot with `stolen`=1. A further note-on steals slot 0, the oldest held.
- `free_valid` for voice 5 in the same cycle as a note-on ISSUE to voice 5: voice 5 stays busy and `active_count` is unchanged.
- Note-off for an unplayed note: no strobe, and `ev_ready` returns at T+N+3. Assert `rst` mid-SCAN: no strobe, and the flags clear.
